// File: rtl/unidad_control_multiciclo_pkg.sv
// paquete_control: shared types and encodings for the multicycle RV32I control unit.
//   - estado_t : FSM states
//   - clase_t  : instruction class produced by the decoder
//   - opcode constants, sel_imm codes (immediate generator encoding),
//     alu_src / pc_src / wb_sel mux encodings
package paquete_control;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } estado_t;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_OPIMM  = 4'd1,
        CL_LUI    = 4'd2,
        CL_AUIPC  = 4'd3,
        CL_LOAD   = 4'd4,
        CL_STORE  = 4'd5,
        CL_BRANCH = 4'd6,
        CL_JAL    = 4'd7,
        CL_JALR   = 4'd8,
        CL_ILEGAL = 4'd9
    } clase_t;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Immediate generator select codes
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_SHAMT = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_B     = 3'b100;
    localparam logic [2:0] IMM_J     = 3'b101;
    localparam logic [2:0] IMM_ZERO  = 3'b111;

    // ALU operand A mux
    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    // ALU operand B mux
    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    // PC source mux
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_ALU    = 2'b01;
    localparam logic [1:0] PC_ALU_AL = 2'b10;  // JALR: bit0 cleared

    // Write-back mux
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;

endpackage

// File: rtl/unidad_control_multiciclo_decodificador.sv
// decodificador_instr: purely combinational instruction decode.
//   instr   in  32 : instruction register contents
//   clase   out    : instruction class
//   sel_imm out  3 : immediate generator select (111 for R-type / illegal)
//   alu_op  out  4 : {funct7[5], funct3} for R and shift-imm, {0, funct3}
//                    for other OP-IMM, ADD otherwise
//   illegal out  1 : opcode not recognised
module decodificador_instr
    import paquete_control::*;
(
    input  logic [31:0] instr,
    output clase_t      clase,
    output logic [2:0]  sel_imm,
    output logic [3:0]  alu_op,
    output logic        illegal
);

    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_bits;

    assign funct3      = instr[14:12];
    assign funct7_5    = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        clase   = CL_ILEGAL;
        sel_imm = IMM_ZERO;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                clase  = CL_R;
                alu_op = {funct7_5, funct3};
            end
            OPC_OPIMM: begin
                clase = CL_OPIMM;
                // Shifts carry the arithmetic/logical select in funct7[5]
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    sel_imm = IMM_SHAMT;
                    alu_op  = {funct7_5, funct3};
                end else begin
                    sel_imm = IMM_I;
                    alu_op  = {1'b0, funct3};
                end
            end
            OPC_LUI: begin
                clase   = CL_LUI;
                sel_imm = IMM_U;
            end
            OPC_AUIPC: begin
                clase   = CL_AUIPC;
                sel_imm = IMM_U;
            end
            OPC_LOAD: begin
                clase   = CL_LOAD;
                sel_imm = IMM_I;
            end
            OPC_STORE: begin
                clase   = CL_STORE;
                sel_imm = IMM_S;
            end
            OPC_BRANCH: begin
                clase   = CL_BRANCH;
                sel_imm = IMM_B;
            end
            OPC_JAL: begin
                clase   = CL_JAL;
                sel_imm = IMM_J;
            end
            OPC_JALR: begin
                clase   = CL_JALR;
                sel_imm = IMM_I;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over a shared
// single-port memory, one instruction in flight.
//   clk, rst (sync, active high)
//   instr, branch_taken, mem_ack              : inputs
//   mem_req, mem_we, mem_addr_sel             : memory handshake
//   ir_we, pc_we, pc_src                      : IR / PC update
//   sel_imm, alu_src_a, alu_src_b, alu_op     : datapath selects
//   rf_we, wb_sel                             : register write-back
//   instr_ret                                 : retired instruction count
//   illegal                                   : sticky illegal flag
// Optional macro ILLEGAL_INSTR_TRAP_EN: illegal opcodes park the FSM in
// TRAP with illegal = 1; otherwise they are dropped as NOPs and illegal = 0.
module unidad_control_multiciclo
    import paquete_control::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [2:0]  sel_imm,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [3:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] instr_ret,
    output logic        illegal
);

    estado_t     estado, estado_sig;
    clase_t      clase;
    logic [2:0]  dec_sel_imm;
    logic [3:0]  dec_alu_op;
    logic        dec_illegal;
    logic [31:0] cnt_ret;
    logic        retira;

    decodificador_instr u_dec (
        .instr   (instr),
        .clase   (clase),
        .sel_imm (dec_sel_imm),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    // An instruction retires when the FSM returns to FETCH from a working state
    assign retira = (estado == S_EXEC || estado == S_MEM || estado == S_WB) &&
                    (estado_sig == S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= S_FETCH;
            cnt_ret <= '0;
        end else begin
            estado <= estado_sig;
            if (retira)
                cnt_ret <= cnt_ret + 32'd1;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            S_FETCH:  if (mem_ack) estado_sig = S_DECODE;
            S_DECODE: begin
                if (dec_illegal) begin
`ifdef ILLEGAL_INSTR_TRAP_EN
                    estado_sig = S_TRAP;
`else
                    estado_sig = S_FETCH;
`endif
                end else begin
                    estado_sig = S_EXEC;
                end
            end
            S_EXEC: begin
                case (clase)
                    CL_BRANCH:         estado_sig = S_FETCH;
                    CL_LOAD, CL_STORE: estado_sig = S_MEM;
                    default:           estado_sig = S_WB;
                endcase
            end
            S_MEM:    if (mem_ack) estado_sig = (clase == CL_LOAD) ? S_WB : S_FETCH;
            S_WB:     estado_sig = S_FETCH;
            S_TRAP:   estado_sig = S_TRAP;
            default:  estado_sig = S_FETCH;
        endcase
    end

    // Output decode. Reset forces the idle values combinationally so a store
    // caught mid-MEM drops mem_we in the same cycle rst rises.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        sel_imm      = IMM_ZERO;
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        if (!rst) begin
            // Immediate and ALU selects stay stable from decode to write-back
            // so a combinational ALU keeps producing the address / result.
            if (estado == S_DECODE || estado == S_EXEC ||
                estado == S_MEM    || estado == S_WB)
                sel_imm = dec_sel_imm;
            if (estado == S_EXEC || estado == S_MEM || estado == S_WB) begin
                alu_op    = dec_alu_op;
                alu_src_b = (clase == CL_R) ? SRC_B_RS2 : SRC_B_IMM;
                case (clase)
                    CL_LUI:                       alu_src_a = SRC_A_ZERO;
                    CL_AUIPC, CL_BRANCH, CL_JAL:  alu_src_a = SRC_A_PC;
                    default:                      alu_src_a = SRC_A_RS1;
                endcase
            end
            case (estado)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                    pc_we   = mem_ack;
                end
                S_EXEC: begin
                    case (clase)
                        CL_BRANCH: begin
                            pc_we  = branch_taken;
                            pc_src = PC_ALU;
                        end
                        CL_JAL: begin
                            pc_we  = 1'b1;
                            pc_src = PC_ALU;
                        end
                        CL_JALR: begin
                            pc_we  = 1'b1;
                            pc_src = PC_ALU_AL;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (clase == CL_STORE);
                end
                S_WB: begin
                    rf_we = 1'b1;
                    case (clase)
                        CL_LOAD:         wb_sel = WB_MEM;
                        CL_JAL, CL_JALR: wb_sel = WB_PC4;
                        default:         wb_sel = WB_ALU;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign instr_ret = rst ? '0 : cnt_ret;

`ifdef ILLEGAL_INSTR_TRAP_EN
    assign illegal = !rst && (estado == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Self-checking bench for unidad_control_multiciclo: directed test-plan
// instructions followed by random legal instructions with random memory
// waits, each compared against a per-phase reference of the instruction
// walk. Honours ILLEGAL_INSTR_TRAP_EN for the illegal-opcode case.
module tb_unidad_control_multiciclo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_src_b, rf_we, illegal;
    logic [1:0]  pc_src, alu_src_a, wb_sel;
    logic [2:0]  sel_imm;
    logic [3:0]  alu_op;
    logic [31:0] instr_ret;

    int checks = 0;
    int errors = 0;
    int retired = 0;
    int ncyc;

    localparam int K_R = 0, K_OPI = 1, K_LUI = 2, K_AUI = 3, K_LD = 4,
                   K_ST = 5, K_BR = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

    unidad_control_multiciclo dut (
        .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .sel_imm(sel_imm), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we),
        .wb_sel(wb_sel), .instr_ret(instr_ret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what the instruction word means, straight from the opcode table
    function automatic void ref_decode(input logic [31:0] w, output int cls,
                                       output logic [2:0] simm, output logic [3:0] aop,
                                       output logic [1:0] sa, output logic sb,
                                       output logic [1:0] ps, output logic [1:0] wbs);
        logic [2:0] f3;
        f3 = w[14:12];
        aop = 4'b0000; sa = 2'b00; sb = 1'b1; ps = 2'b00; wbs = 2'b00; simm = 3'b111;
        case (w[6:0])
            7'h33: begin cls = K_R; sb = 1'b0; aop = {w[30], f3}; end
            7'h13: begin
                cls = K_OPI;
                if (f3 == 3'b001 || f3 == 3'b101) begin simm = 3'b001; aop = {w[30], f3}; end
                else begin simm = 3'b000; aop = {1'b0, f3}; end
            end
            7'h37: begin cls = K_LUI; simm = 3'b011; sa = 2'b10; end
            7'h17: begin cls = K_AUI; simm = 3'b011; sa = 2'b01; end
            7'h03: begin cls = K_LD;  simm = 3'b000; wbs = 2'b01; end
            7'h23: begin cls = K_ST;  simm = 3'b010; end
            7'h63: begin cls = K_BR;  simm = 3'b100; sa = 2'b01; ps = 2'b01; end
            7'h6f: begin cls = K_JAL; simm = 3'b101; sa = 2'b01; ps = 2'b01; wbs = 2'b10; end
            7'h67: begin cls = K_JALR; simm = 3'b000; ps = 2'b10; wbs = 2'b10; end
            default: cls = K_ILL;
        endcase
    endfunction

    // Walk one instruction through the DUT, checking every cycle.
    // fw/mw: wait cycles before the fetch/memory ack; tk: branch outcome.
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw,
                             input logic tk, output int nc);
        int cls; logic [2:0] simm; logic [3:0] aop; logic [1:0] sa, ps, wbs; logic sb;
        ref_decode(w, cls, simm, aop, sa, sb, ps, wbs);
        nc = 0;
        for (int i = 0; i <= fw; i++) begin
            instr = $urandom; mem_ack = (i == fw); branch_taken = 1'($urandom_range(0, 1));
            #4;
            chk("fetch.mem_req", mem_req, 1);
            chk("fetch.addr_sel", mem_addr_sel, 0);
            chk("fetch.mem_we", mem_we, 0);
            chk("fetch.ir_we", ir_we, (i == fw));
            chk("fetch.pc_we", pc_we, (i == fw));
            chk("fetch.pc_src", pc_src, 0);
            chk("fetch.sel_imm", sel_imm, 3'b111);
            chk("fetch.rf_we", rf_we, 0);
            chk("fetch.instr_ret", instr_ret, retired);
            step(); nc++;
        end
        instr = w; mem_ack = 1'b0;
        #4;
        chk("decode.sel_imm", sel_imm, simm);
        chk("decode.mem_req", mem_req, 0);
        chk("decode.pc_we", pc_we, 0);
        chk("decode.rf_we", rf_we, 0);
        chk("decode.illegal", illegal, 0);
        step(); nc++;
        if (cls == K_ILL) return;
        branch_taken = tk;
        #4;
        chk("exec.alu_src_a", alu_src_a, sa);
        chk("exec.alu_src_b", alu_src_b, sb);
        chk("exec.alu_op", alu_op, aop);
        chk("exec.sel_imm", sel_imm, simm);
        chk("exec.pc_we", pc_we, (cls == K_BR) ? tk : (cls == K_JAL || cls == K_JALR));
        chk("exec.pc_src", pc_src, ps);
        chk("exec.mem_req", mem_req, 0);
        chk("exec.rf_we", rf_we, 0);
        chk("exec.ir_we", ir_we, 0);
        step(); nc++;
        if (cls == K_BR) begin retired++; return; end
        if (cls == K_LD || cls == K_ST) begin
            for (int i = 0; i <= mw; i++) begin
                mem_ack = (i == mw);
                #4;
                chk("mem.mem_req", mem_req, 1);
                chk("mem.addr_sel", mem_addr_sel, 1);
                chk("mem.mem_we", mem_we, (cls == K_ST));
                chk("mem.sel_imm", sel_imm, simm);
                chk("mem.rf_we", rf_we, 0);
                chk("mem.pc_we", pc_we, 0);
                step(); nc++;
            end
            mem_ack = 1'b0;
            if (cls == K_ST) begin retired++; return; end
        end
        #4;
        chk("wb.rf_we", rf_we, 1);
        chk("wb.wb_sel", wb_sel, wbs);
        chk("wb.sel_imm", sel_imm, simm);
        chk("wb.mem_req", mem_req, 0);
        chk("wb.pc_we", pc_we, 0);
        step(); nc++;
        retired++;
    endtask

    initial begin : stim
        logic [6:0] ops [9];
        logic [31:0] w;
        int fw, mw, exp_nc, cls;
        logic [2:0] simm; logic [3:0] aop; logic [1:0] sa, ps, wbs; logic sb;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};

        rst = 1'b1; instr = 32'h0; branch_taken = 1'b0; mem_ack = 1'b0;
        #1;
        step(); step();
        #4;
        chk("rst.mem_req", mem_req, 0);
        chk("rst.sel_imm", sel_imm, 3'b111);
        chk("rst.ir_we", ir_we, 0);
        chk("rst.pc_we", pc_we, 0);
        chk("rst.instr_ret", instr_ret, 0);
        chk("rst.illegal", illegal, 0);
        step();
        rst = 1'b0;

        run_instr(32'h00500093, 0, 0, 1'b0, ncyc); chk("addi.cycles", ncyc, 4);
        chk("addi.retired", instr_ret, 1);
        run_instr(32'h00309093, 0, 0, 1'b0, ncyc); chk("slli.cycles", ncyc, 4);
        run_instr(32'h4030d093, 1, 0, 1'b0, ncyc); chk("srai.cycles", ncyc, 5);
        run_instr(32'h00000463, 0, 0, 1'b1, ncyc); chk("beq_t.cycles", ncyc, 3);
        run_instr(32'h00000463, 0, 0, 1'b0, ncyc); chk("beq_nt.cycles", ncyc, 3);
        run_instr(32'h0000a103, 0, 2, 1'b0, ncyc); chk("lw.cycles", ncyc, 7);
        run_instr(32'h0020a023, 0, 0, 1'b0, ncyc); chk("sw.cycles", ncyc, 4);
        run_instr(32'h008000ef, 0, 0, 1'b0, ncyc); chk("jal.cycles", ncyc, 4);
        run_instr(32'h000080e7, 0, 0, 1'b0, ncyc); chk("jalr.cycles", ncyc, 4);

        for (int n = 0; n < 60; n++) begin
            w = {$urandom_range(0, 32'h01FF_FFFF) , 7'h00};
            w[6:0] = ops[$urandom_range(0, 8)];
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            ref_decode(w, cls, simm, aop, sa, sb, ps, wbs);
            exp_nc = (fw + 1) + 2 + ((cls == K_LD || cls == K_ST) ? mw + 1 : 0) +
                     ((cls == K_BR || cls == K_ST) ? 0 : 1);
            run_instr(w, fw, mw, 1'($urandom_range(0, 1)), ncyc);
            chk("rand.cycles", ncyc, exp_nc);
        end

        // Reset while a store waits in MEM
        instr = $urandom; mem_ack = 1'b1;
        #4; step();
        instr = 32'h0020a023; mem_ack = 1'b0;
        #4; step();                       // DECODE
        #4; step();                       // EXEC
        #4;
        chk("rstmem.mem_we_before", mem_we, 1);
        step();                           // MEM, still waiting
        rst = 1'b1;
        #4;
        chk("rstmem.mem_we", mem_we, 0);
        chk("rstmem.mem_req", mem_req, 0);
        chk("rstmem.sel_imm", sel_imm, 3'b111);
        chk("rstmem.instr_ret", instr_ret, 0);
        step();
        rst = 1'b0; retired = 0;
        #4;
        chk("rstmem.fetch_req", mem_req, 1);
        chk("rstmem.fetch_addr", mem_addr_sel, 0);
        chk("rstmem.instr_ret_after", instr_ret, 0);
        step();
        run_instr(32'h00500093, 0, 0, 1'b0, ncyc);
        chk("post_rst.instr_ret", instr_ret, 1);

        // Illegal opcode
        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, ncyc);
        chk("ill.cycles", ncyc, 2);
`ifdef ILLEGAL_INSTR_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            mem_ack = 1'b1; instr = $urandom;
            #4;
            chk("trap.illegal", illegal, 1);
            chk("trap.mem_req", mem_req, 0);
            chk("trap.ir_we", ir_we, 0);
            chk("trap.pc_we", pc_we, 0);
            chk("trap.rf_we", rf_we, 0);
            chk("trap.instr_ret", instr_ret, retired);
            step();
        end
        mem_ack = 1'b0; rst = 1'b1;
        #4;
        chk("trap.rst_illegal", illegal, 0);
        step();
        rst = 1'b0; retired = 0;
`else
        mem_ack = 1'b0;
        #4;
        chk("ill.back_fetch", mem_req, 1);
        chk("ill.illegal", illegal, 0);
        chk("ill.instr_ret", instr_ret, retired);
        step();
`endif
        run_instr(32'h00000463, 0, 0, 1'b1, ncyc);
        chk("final.instr_ret", instr_ret, retired);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
